// File: rtl/io_fcs_pkg.sv
// io_fcs_pkg: shared state encoding, FCS/GAP constants and the byte-wise CRC-32 step.
package io_fcs_pkg;

    localparam int unsigned FCS_BYTES = 4;
    localparam int unsigned GAP_CYC   = 12;
    localparam int unsigned FCS_IDX_W = 3;
    localparam int unsigned GAP_CNT_W = 4;
    localparam int unsigned FRM_CNT_W = 16;

    localparam logic [31:0] CRC_SEED = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY = 32'hEDB8_8320;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_FCS  = 2'd2,
        ST_GAP  = 2'd3
    } fcs_state_e;

    // One output beat: framing flags plus the byte.
    typedef struct packed {
        logic       sop;
        logic       eop;
        logic [7:0] data;
    } fcs_beat_t;

    // Reflected CRC-32 update over one byte, LSB first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] din);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            c = (c[0] ^ din[i]) ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/io_fcs32.sv
// io_fcs32: byte-wise CRC-32 engine; crc_dout holds the complemented CRC
// byte-swapped so that [31:24] is the first byte on the wire.
module io_fcs32
    import io_fcs_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  crc_din,
    input  logic        crc_sop,
    input  logic        crc_din_vld,
    input  logic        crc_cap,
    output logic [31:0] crc_dout
);

    logic [31:0] r_crc;
    logic [31:0] r_dout;
    logic [31:0] w_crc_nxt;
    logic [31:0] w_fcs;

    assign w_crc_nxt = crc32_byte(r_crc, crc_din);
    assign w_fcs     = ~w_crc_nxt;
    assign crc_dout  = r_dout;

    // Running CRC: advance on each byte, reseed between frames.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_crc <= CRC_SEED;
        end else if (crc_din_vld) begin
            r_crc <= w_crc_nxt;
        end else if (crc_sop) begin
            r_crc <= CRC_SEED;
        end
    end

    // Capture the final FCS together with the last frame byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dout <= '0;
        end else if (crc_din_vld && crc_cap) begin
            r_dout <= {w_fcs[7:0], w_fcs[15:8], w_fcs[23:16], w_fcs[31:24]};
        end
    end

endmodule

// File: rtl/io_fcs_tx_frm.sv
// io_fcs_tx_frm: forwards a framed byte stream and appends a 4-byte CRC-32 FCS.
// Optional inter-frame gap of GAP_CYC idle cycles when FCS_TX_GAP_EN is defined.
module io_fcs_tx_frm
    import io_fcs_pkg::*;
(
    input  logic                 clk_sys,
    input  logic                 rst_sys,
    input  logic [7:0]           s_data,
    input  logic                 s_vld,
    input  logic                 s_sop,
    input  logic                 s_eop,
    output logic                 s_rdy,
    output logic [7:0]           m_data,
    output logic                 m_vld,
    output logic                 m_sop,
    output logic                 m_eop,
    input  logic                 m_rdy,
    output logic [FRM_CNT_W-1:0] frm_cnt,
    output logic                 err_pls
);

    fcs_state_e             r_state;
    fcs_state_e             w_state_nxt;
    fcs_beat_t              r_beat;
    logic                   r_m_vld;
    logic                   r_rdy_en;
    logic                   r_err;
    logic [FCS_IDX_W-1:0]   r_fcs_idx;
    logic [FRM_CNT_W-1:0]   r_frm_cnt;

    logic                   w_load;
    logic                   w_src_st;
    logic                   w_acc;
    logic                   w_fwd;
    logic                   w_err;
    logic                   w_fcs_load;
    logic                   w_fcs_done;
    logic [7:0]             w_fcs_byte;
    logic [31:0]            w_crc_dout;
    logic                   w_crc_sop;
    logic                   w_crc_vld;
    logic                   w_crc_cap;
    logic                   w_rst_n;

    // Output register may take a new beat when empty or being drained.
    assign w_load     = !r_m_vld || m_rdy;
    assign w_src_st   = (r_state == ST_IDLE) || (r_state == ST_DATA);
    // r_rdy_en keeps s_rdy low until the first edge after reset release.
    assign s_rdy      = r_rdy_en && w_src_st && w_load;
    assign w_acc      = s_vld && s_rdy;
    assign w_fwd      = w_acc && ((r_state == ST_DATA) || s_sop);
    assign w_err      = w_acc && ((r_state == ST_IDLE) ? !s_sop : s_sop);
    assign w_fcs_load = (r_state == ST_FCS) && w_load && (r_fcs_idx < FCS_IDX_W'(FCS_BYTES));
    assign w_fcs_done = (r_state == ST_FCS) && r_m_vld && m_rdy && r_beat.eop;

    // CRC stays seeded whenever no frame is in progress.
    assign w_crc_sop  = (r_state != ST_DATA) && !w_fwd;
    assign w_crc_vld  = w_fwd;
    assign w_crc_cap  = w_fwd && s_eop;
    assign w_rst_n    = ~rst_sys;

    assign m_data     = r_beat.data;
    assign m_sop      = r_beat.sop;
    assign m_eop      = r_beat.eop;
    assign m_vld      = r_m_vld;
    assign frm_cnt    = r_frm_cnt;
    assign err_pls    = r_err;

    io_fcs32 u_fcs32 (
        .clk         (clk_sys),
        .rst_n       (w_rst_n),
        .crc_din     (s_data),
        .crc_sop     (w_crc_sop),
        .crc_din_vld (w_crc_vld),
        .crc_cap     (w_crc_cap),
        .crc_dout    (w_crc_dout)
    );

    // Select the FCS byte to emit, most significant first.
    always_comb begin
        w_fcs_byte = w_crc_dout[31:24];
        case (r_fcs_idx[1:0])
            2'd1:    w_fcs_byte = w_crc_dout[23:16];
            2'd2:    w_fcs_byte = w_crc_dout[15:8];
            2'd3:    w_fcs_byte = w_crc_dout[7:0];
            default: w_fcs_byte = w_crc_dout[31:24];
        endcase
    end

`ifdef FCS_TX_GAP_EN
    logic [GAP_CNT_W-1:0] r_gap_cnt;
    logic                 w_gap_end;

    assign w_gap_end = (r_gap_cnt == GAP_CNT_W'(GAP_CYC - 1));

    // Counts cycles spent in GAP.
    always_ff @(posedge clk_sys or posedge rst_sys) begin
        if (rst_sys) begin
            r_gap_cnt <= '0;
        end else if (r_state == ST_GAP) begin
            r_gap_cnt <= r_gap_cnt + GAP_CNT_W'(1);
        end else begin
            r_gap_cnt <= '0;
        end
    end
`endif

    // State register.
    always_ff @(posedge clk_sys or posedge rst_sys) begin
        if (rst_sys) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_fwd) begin
                    w_state_nxt = s_eop ? ST_FCS : ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_acc && s_eop) begin
                    w_state_nxt = ST_FCS;
                end
            end
            ST_FCS: begin
                if (w_fcs_done) begin
`ifdef FCS_TX_GAP_EN
                    w_state_nxt = ST_GAP;
`else
                    w_state_nxt = ST_IDLE;
`endif
                end
            end
`ifdef FCS_TX_GAP_EN
            ST_GAP: begin
                if (w_gap_end) begin
                    w_state_nxt = ST_IDLE;
                end
            end
`endif
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Output register: payload byte, then FCS bytes; holds while stalled.
    always_ff @(posedge clk_sys or posedge rst_sys) begin
        if (rst_sys) begin
            r_m_vld <= 1'b0;
            r_beat  <= '0;
        end else if (w_load) begin
            if (w_fwd) begin
                r_m_vld     <= 1'b1;
                r_beat.sop  <= (r_state == ST_IDLE);
                r_beat.eop  <= 1'b0;
                r_beat.data <= s_data;
            end else if (w_fcs_load) begin
                r_m_vld     <= 1'b1;
                r_beat.sop  <= 1'b0;
                r_beat.eop  <= (r_fcs_idx == FCS_IDX_W'(FCS_BYTES - 1));
                r_beat.data <= w_fcs_byte;
            end else begin
                r_m_vld    <= 1'b0;
                r_beat.sop <= 1'b0;
                r_beat.eop <= 1'b0;
            end
        end
    end

    // FCS byte index, cleared outside FCS.
    always_ff @(posedge clk_sys or posedge rst_sys) begin
        if (rst_sys) begin
            r_fcs_idx <= '0;
        end else if (r_state != ST_FCS) begin
            r_fcs_idx <= '0;
        end else if (w_fcs_load) begin
            r_fcs_idx <= r_fcs_idx + FCS_IDX_W'(1);
        end
    end

    // Frame counter, error pulse and post-reset ready enable.
    always_ff @(posedge clk_sys or posedge rst_sys) begin
        if (rst_sys) begin
            r_frm_cnt <= '0;
            r_err     <= 1'b0;
            r_rdy_en  <= 1'b0;
        end else begin
            r_err    <= w_err;
            r_rdy_en <= 1'b1;
            if (w_fcs_done) begin
                r_frm_cnt <= r_frm_cnt + FRM_CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/io_fcs_tx_frm.md
IO_FCS_TX_FRM -- requirements
Module: io_fcs_tx_frm

Interface
REQ-001 SHALL have these ports, clock and reset first:
- clk_sys  in  1  system clock; single clock domain.
- rst_sys  in  1  reset, asynchronous, active-high.
- s_data  in  8  payload byte.
- s_vld  in  1  payload byte valid.
- s_sop  in  1  first byte of frame.
- s_eop  in  1  last byte of frame.
- s_rdy  out  1  payload byte accepted when s_vld & s_rdy.
- m_data  out  8  output byte (payload followed by FCS).
- m_vld  out  1  output byte valid.
- m_sop  out  1  first output byte.
- m_eop  out  1  last FCS byte.
- m_rdy  in  1  downstream accept.
- frm_cnt  out  16  count of completed frames.
- err_pls  out  1  one-cycle protocol-error pulse.

Function
REQ-002 SHALL implement the state machine IDLE -> DATA -> FCS -> (GAP) -> IDLE.
REQ-003 SHALL drive s_rdy = 1 only in IDLE or DATA, and only when the output register is empty or m_rdy = 1.
REQ-004 SHALL, in IDLE:
- on an accepted byte with s_sop = 1, forward the byte and enter DATA;
- on an accepted byte with s_sop = 0, discard it and pulse err_pls.
REQ-005 SHALL, in DATA, forward every accepted byte.
- s_sop = 1 seen in DATA pulses err_pls; the byte is still forwarded as data.
REQ-006 SHALL present each forwarded byte on m_data/m_vld one cycle after acceptance.
- The output register SHALL hold its value while m_vld & !m_rdy.
REQ-007 SHALL feed the CRC sub-module with every accepted frame byte:
- crc_sop pulses on the cycle before the first byte;
- crc_din_vld is asserted on each accepted byte;
- crc_cap is asserted together with the s_eop byte.
REQ-008 SHALL handle a byte carrying both s_sop and s_eop as a one-byte frame: IDLE -> FCS directly.
REQ-009 SHALL, in FCS, emit 4 bytes in the order crc_dout[31:24], [23:16], [15:8], [7:0].
- The first FCS byte follows the last payload byte with no bubble when m_rdy stays high.
- m_eop is asserted on the 4th FCS byte.
REQ-010 SHALL increment frm_cnt on acceptance of the 4th FCS byte; frm_cnt wraps 0xFFFF -> 0x0000.
REQ-011 SHALL drive m_sop only on the first payload byte.
REQ-012 SHALL impose no frame-length limit.

Reset
REQ-013 SHALL, on rst_sys (asynchronous, anytime, including mid-frame):
- set state = IDLE, m_vld = 0, m_sop = 0, m_eop = 0, m_data = 0x00, s_rdy = 0, frm_cnt = 0, err_pls = 0;
- reset the CRC engine to its seed;
- discard any partial frame, with no FCS emitted.
REQ-014 SHALL raise s_rdy no earlier than the first clk_sys edge after rst_sys deasserts.

Configuration
REQ-015 SHALL, with FCS_TX_GAP_EN defined, enter GAP after the 4th FCS byte is accepted.
- GAP holds s_rdy = 0 and m_vld = 0 for exactly 12 cycles, then returns to IDLE.
- Without FCS_TX_GAP_EN, FCS returns directly to IDLE and GAP logic is absent.

Structure
REQ-016 SHALL take the following from shared package io_fcs_pkg:
- the state encoding;
- FCS_BYTES = 4;
- GAP_CYC = 12;
- CRC seed = 0xFFFFFFFF.
REQ-017 SHALL instantiate exactly one sub-module, the byte-wise CRC-32 engine io_fcs32.
- io_fcs32 takes crc_din, crc_sop, crc_din_vld and crc_cap, and produces crc_dout.
- Its reset input is driven by ~rst_sys.

Verification
REQ-018 "123456789" (0x31..0x39), m_rdy = 1 -> 13 bytes out:
- the 9 payload bytes, then 0x26 0x39 0xF4 0xCB;
- m_sop on 0x31, m_eop on 0xCB, frm_cnt = 1.
REQ-019 Single byte 0x00 with s_sop = s_eop = 1 -> m_data 0x00, 0x8D, 0xEF, 0x02, 0xD2; m_eop on 0xD2.
REQ-020 "123456789" with m_rdy toggling 1/0 every cycle -> identical byte sequence, with no drop or duplicate.
REQ-021 rst_sys pulsed after the 5th payload byte, then "123456789" resent -> only the second frame appears with correct FCS; frm_cnt = 1.
REQ-022 Byte with s_sop = 0 in IDLE -> discarded, err_pls = 1 for one cycle, m_vld stays 0.
REQ-023 FCS_TX_GAP_EN defined, two back-to-back frames -> exactly 12 cycles with s_rdy = 0 between m_eop and the next accepted byte.
